// File: rtl/i2c_cmd_arbiter_pkg.sv
// Shared types and constants for the two-requester I2C command arbiter.
package i2c_cmd_arbiter_pkg;

    localparam int unsigned REQ_N           = 2;
    localparam int unsigned TIMEOUT_DFLT    = 255;
    localparam int unsigned DATA_DEPTH_DFLT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    // Requester index to one-hot grant vector.
    function automatic logic [REQ_N-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_if.sv
// Arbiter-to-I2C-master bus: command channels, write/read data and status pulses.
interface i2c_cmd_arbiter_if #(
    parameter int unsigned DATA_DEPTH = i2c_cmd_arbiter_pkg::DATA_DEPTH_DFLT
);
    logic                  o_start;
    logic [DATA_DEPTH-1:0] o_addr_bits;
    logic                  o_addr_valid;
    logic [DATA_DEPTH-1:0] o_nbytes_bits;
    logic                  o_nbytes_valid;
    logic [DATA_DEPTH-1:0] o_data_write_bits;
    logic                  o_data_write_valid;
    logic                  o_data_read_ready;
    logic                  i_addr_ready;
    logic                  i_nbytes_ready;
    logic                  i_data_write_ready;
    logic [DATA_DEPTH-1:0] i_data_read_bits;
    logic                  i_data_read_valid;
    logic                  i_xfer_done;
    logic                  i_nack;

    modport master (
        output o_start, o_addr_bits, o_addr_valid, o_nbytes_bits, o_nbytes_valid,
               o_data_write_bits, o_data_write_valid, o_data_read_ready,
        input  i_addr_ready, i_nbytes_ready, i_data_write_ready,
               i_data_read_bits, i_data_read_valid, i_xfer_done, i_nack
    );

    modport slave (
        input  o_start, o_addr_bits, o_addr_valid, o_nbytes_bits, o_nbytes_valid,
               o_data_write_bits, o_data_write_valid, o_data_read_ready,
        output i_addr_ready, i_nbytes_ready, i_data_write_ready,
               i_data_read_bits, i_data_read_valid, i_xfer_done, i_nack
    );
endinterface

// File: rtl/i2c_cmd_arbiter_rr_pick2.sv
// Two-input round-robin picker: on contention the requester not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C master between two requesters; a granted transaction runs to its stop.
module i2c_cmd_arbiter
    import i2c_cmd_arbiter_pkg::*;
#(
    parameter int unsigned DATA_DEPTH = DATA_DEPTH_DFLT,
    parameter int unsigned TIMEOUT    = TIMEOUT_DFLT
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [REQ_N-1:0]            i_req,
    output logic [REQ_N-1:0]            o_gnt,
    input  logic [REQ_N-1:0]            i_rq_start,
    input  logic [REQ_N*DATA_DEPTH-1:0] i_rq_addr_bits,
    input  logic [REQ_N*DATA_DEPTH-1:0] i_rq_nbytes_bits,
    input  logic [REQ_N*DATA_DEPTH-1:0] i_rq_wdata_bits,
    input  logic [REQ_N-1:0]            i_rq_addr_valid,
    input  logic [REQ_N-1:0]            i_rq_nbytes_valid,
    input  logic [REQ_N-1:0]            i_rq_wdata_valid,
    output logic [REQ_N-1:0]            o_rq_addr_ready,
    output logic [REQ_N-1:0]            o_rq_nbytes_ready,
    output logic [REQ_N-1:0]            o_rq_wdata_ready,
    output logic [DATA_DEPTH-1:0]       o_rq_rdata_bits,
    output logic [REQ_N-1:0]            o_rq_rdata_valid,
    input  logic [REQ_N-1:0]            i_rq_rdata_ready,
    i2c_cmd_arbiter_if.master           m_if,
    output logic                        o_timeout,
    output logic [REQ_N-1:0]            o_nack_src
);
    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REQ_N-1:0]  nack_q, nack_d;
    logic [REQ_N-1:0]  pick;
    logic              active;

    rr_pick2 u_pick (.req(i_req), .last(last_q), .gnt(pick));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            nack_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            nack_q  <= nack_d;
        end
    end

    // Start beats a dropped request, which beats the timeout.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        nack_d    = nack_q;
        o_timeout = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    state_d = ST_GRANT;
                    owner_d = pick[1];
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (i_rq_start[owner_q]) begin
                    state_d = ST_BUSY;
                end else if (!i_req[owner_q]) begin
                    state_d = ST_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    o_timeout = 1'b1;
                    state_d   = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BUSY: begin
                if (m_if.i_nack)      nack_d  = idx_to_onehot(owner_q);
                if (m_if.i_xfer_done) state_d = ST_GAP;
            end
            ST_GAP: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign active     = (state_q == ST_GRANT) || (state_q == ST_BUSY);
    assign o_gnt      = active ? idx_to_onehot(owner_q) : '0;
    assign o_nack_src = nack_q;

    // Owner's request channels pass straight through to the master and back.
    always_comb begin
        m_if.o_start            = 1'b0;
        m_if.o_addr_bits        = '0;
        m_if.o_addr_valid       = 1'b0;
        m_if.o_nbytes_bits      = '0;
        m_if.o_nbytes_valid     = 1'b0;
        m_if.o_data_write_bits  = '0;
        m_if.o_data_write_valid = 1'b0;
        m_if.o_data_read_ready  = 1'b0;
        o_rq_addr_ready         = '0;
        o_rq_nbytes_ready       = '0;
        o_rq_wdata_ready        = '0;
        o_rq_rdata_valid        = '0;
        o_rq_rdata_bits         = m_if.i_data_read_bits;
        if (active) begin
            m_if.o_start            = i_rq_start[owner_q];
            m_if.o_addr_bits        = owner_q ? i_rq_addr_bits[DATA_DEPTH +: DATA_DEPTH]
                                              : i_rq_addr_bits[0 +: DATA_DEPTH];
            m_if.o_addr_valid       = i_rq_addr_valid[owner_q];
            m_if.o_nbytes_bits      = owner_q ? i_rq_nbytes_bits[DATA_DEPTH +: DATA_DEPTH]
                                              : i_rq_nbytes_bits[0 +: DATA_DEPTH];
            m_if.o_nbytes_valid     = i_rq_nbytes_valid[owner_q];
            m_if.o_data_write_bits  = owner_q ? i_rq_wdata_bits[DATA_DEPTH +: DATA_DEPTH]
                                              : i_rq_wdata_bits[0 +: DATA_DEPTH];
            m_if.o_data_write_valid = i_rq_wdata_valid[owner_q];
            m_if.o_data_read_ready  = i_rq_rdata_ready[owner_q];
            o_rq_addr_ready[owner_q]   = m_if.i_addr_ready;
            o_rq_nbytes_ready[owner_q] = m_if.i_nbytes_ready;
            o_rq_wdata_ready[owner_q]  = m_if.i_data_write_ready;
            o_rq_rdata_valid[owner_q]  = m_if.i_data_read_valid;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_i2c_cmd_arbiter;
    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 255;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [1:0]      i_req, o_gnt, i_rq_start;
    logic [2*DW-1:0] i_rq_addr_bits, i_rq_nbytes_bits, i_rq_wdata_bits;
    logic [1:0]      i_rq_addr_valid, i_rq_nbytes_valid, i_rq_wdata_valid;
    logic [1:0]      o_rq_addr_ready, o_rq_nbytes_ready, o_rq_wdata_ready;
    logic [DW-1:0]   o_rq_rdata_bits;
    logic [1:0]      o_rq_rdata_valid, i_rq_rdata_ready, o_nack_src;
    logic            o_timeout;

    i2c_cmd_arbiter_if #(.DATA_DEPTH(DW)) bus ();

    i2c_cmd_arbiter #(.DATA_DEPTH(DW), .TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .o_gnt(o_gnt), .i_rq_start(i_rq_start),
        .i_rq_addr_bits(i_rq_addr_bits), .i_rq_nbytes_bits(i_rq_nbytes_bits),
        .i_rq_wdata_bits(i_rq_wdata_bits), .i_rq_addr_valid(i_rq_addr_valid),
        .i_rq_nbytes_valid(i_rq_nbytes_valid), .i_rq_wdata_valid(i_rq_wdata_valid),
        .o_rq_addr_ready(o_rq_addr_ready), .o_rq_nbytes_ready(o_rq_nbytes_ready),
        .o_rq_wdata_ready(o_rq_wdata_ready), .o_rq_rdata_bits(o_rq_rdata_bits),
        .o_rq_rdata_valid(o_rq_rdata_valid), .i_rq_rdata_ready(i_rq_rdata_ready),
        .m_if(bus), .o_timeout(o_timeout), .o_nack_src(o_nack_src)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level model: who owns the master, whether a transfer is open.
    int         m_owner;
    int         m_last;
    int         m_wait;
    bit         m_busy;
    bit         m_gap;
    logic [1:0] m_nack;

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_wait = 0; m_busy = 0; m_gap = 0; m_nack = 2'b00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rnd_data();
        i_rq_addr_bits    = 16'($urandom);
        i_rq_nbytes_bits  = 16'($urandom);
        i_rq_wdata_bits   = 16'($urandom);
        i_rq_addr_valid   = 2'($urandom);
        i_rq_nbytes_valid = 2'($urandom);
        i_rq_wdata_valid  = 2'($urandom);
        i_rq_rdata_ready  = 2'($urandom);
        bus.i_addr_ready       = 1'($urandom);
        bus.i_nbytes_ready     = 1'($urandom);
        bus.i_data_write_ready = 1'($urandom);
        bus.i_data_read_bits   = 8'($urandom);
        bus.i_data_read_valid  = 1'($urandom);
    endtask

    // Compare every output against what the model says the current owner should see.
    task automatic check_all();
        bit act;
        logic [1:0] sh_one;
        act = (m_owner >= 0) && !m_gap;
        sh_one = act ? (2'b01 << m_owner) : 2'b00;
        chk("gnt", 32'(o_gnt), 32'(sh_one));
        chk("nack_src", 32'(o_nack_src), 32'(m_nack));
        chk("rdata_bits", 32'(o_rq_rdata_bits), 32'(bus.i_data_read_bits));
        if (act) begin
            chk("timeout", 32'(o_timeout), 32'(!m_busy && m_wait == TMO - 1 &&
                !i_rq_start[m_owner] && i_req[m_owner]));
            chk("start", 32'(bus.o_start), 32'(i_rq_start[m_owner]));
            chk("addr", 32'(bus.o_addr_bits), 32'(i_rq_addr_bits[m_owner*DW +: DW]));
            chk("addr_v", 32'(bus.o_addr_valid), 32'(i_rq_addr_valid[m_owner]));
            chk("nbytes", 32'(bus.o_nbytes_bits), 32'(i_rq_nbytes_bits[m_owner*DW +: DW]));
            chk("nbytes_v", 32'(bus.o_nbytes_valid), 32'(i_rq_nbytes_valid[m_owner]));
            chk("wdata", 32'(bus.o_data_write_bits), 32'(i_rq_wdata_bits[m_owner*DW +: DW]));
            chk("wdata_v", 32'(bus.o_data_write_valid), 32'(i_rq_wdata_valid[m_owner]));
            chk("rd_ready", 32'(bus.o_data_read_ready), 32'(i_rq_rdata_ready[m_owner]));
            chk("rq_addr_rdy", 32'(o_rq_addr_ready), 32'(bus.i_addr_ready ? sh_one : 2'b00));
            chk("rq_nb_rdy", 32'(o_rq_nbytes_ready), 32'(bus.i_nbytes_ready ? sh_one : 2'b00));
            chk("rq_wd_rdy", 32'(o_rq_wdata_ready), 32'(bus.i_data_write_ready ? sh_one : 2'b00));
            chk("rq_rd_v", 32'(o_rq_rdata_valid), 32'(bus.i_data_read_valid ? sh_one : 2'b00));
        end else begin
            chk("idle_outs", 32'({o_timeout, bus.o_start, bus.o_addr_bits, bus.o_addr_valid,
                bus.o_nbytes_valid, bus.o_data_write_valid, bus.o_data_read_ready}), 32'd0);
            chk("idle_bus", 32'({bus.o_nbytes_bits, bus.o_data_write_bits}), 32'd0);
            chk("idle_rdy", 32'({o_rq_addr_ready, o_rq_nbytes_ready, o_rq_wdata_ready,
                o_rq_rdata_valid}), 32'd0);
        end
    endtask

    task automatic model_update();
        if (m_gap) begin
            m_last = m_owner; m_owner = -1; m_gap = 0; m_busy = 0;
        end else if (m_owner < 0) begin
            if (i_req != 2'b00) begin
                m_owner = (i_req == 2'b11) ? 1 - m_last : (i_req[1] ? 1 : 0);
                m_wait = 0; m_busy = 0;
            end
        end else if (m_busy) begin
            if (bus.i_nack) m_nack = 2'b01 << m_owner;
            if (bus.i_xfer_done) m_gap = 1;
        end else if (i_rq_start[m_owner]) m_busy = 1;
        else if (!i_req[m_owner]) m_gap = 1;
        else if (m_wait == TMO - 1) m_gap = 1;
        else m_wait++;
    endtask

    task automatic settle();
        #3;
        check_all();
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_update();
        #1;
        rnd_data();
    endtask

    initial begin
        i_rst = 1'b1; i_req = 2'b00; i_rq_start = 2'b00;
        bus.i_xfer_done = 1'b0; bus.i_nack = 1'b0;
        rnd_data();
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_nack", 32'(o_nack_src), 32'd0);
        chk("rst_outs", 32'({o_timeout, bus.o_start, bus.o_addr_valid}), 32'd0);
        i_rst = 1'b0;

        // Contention after reset: requester 0 first, then requester 1.
        i_req = 2'b11;
        settle(); chk("rr_idle", 32'(o_gnt), 32'd0); tick();
        i_rq_start = 2'b01; i_rq_addr_bits[7:0] = 8'h4E; i_rq_addr_valid = 2'b01; bus.i_addr_ready = 1'b1;
        settle();
        chk("rr_first", 32'(o_gnt), 32'h1);
        chk("fwd_start", 32'(bus.o_start), 32'h1);
        chk("fwd_addr", 32'(bus.o_addr_bits), 32'h4E);
        chk("rdy_route", 32'(o_rq_addr_ready), 32'h1);
        tick();
        i_rq_start = 2'b00; bus.i_xfer_done = 1'b1;
        settle(); tick();
        bus.i_xfer_done = 1'b0;
        settle(); chk("gap_gnt", 32'(o_gnt), 32'd0); tick();
        settle(); tick();
        settle(); chk("rr_second", 32'(o_gnt), 32'h2);

        // NACK and stop in the same cycle while requester 1 is busy.
        i_rq_start = 2'b10; tick();
        i_rq_start = 2'b00; bus.i_nack = 1'b1; bus.i_xfer_done = 1'b1;
        settle(); tick();
        bus.i_nack = 1'b0; bus.i_xfer_done = 1'b0;
        settle();
        chk("nack_src", 32'(o_nack_src), 32'h2);
        chk("nack_gap", 32'(o_gnt), 32'd0);
        tick();

        // Requester 1 holds its grant without starting until it times out.
        i_req = 2'b10;
        settle(); tick();
        for (int c = 1; c <= int'(TMO); c++) begin
            settle();
            if (c == int'(TMO)) chk("timeout_pulse", 32'(o_timeout), 32'h1);
            else if (c == int'(TMO) - 1) chk("timeout_early", 32'(o_timeout), 32'h0);
            tick();
        end
        settle(); chk("timeout_gap", 32'(o_gnt), 32'd0); tick();

        // A busy transfer is not preempted by a request change.
        i_req = 2'b01;
        settle(); tick();
        i_rq_start = 2'b01; settle(); tick();
        i_rq_start = 2'b00; i_req = 2'b10;
        for (int c = 0; c < 3; c++) begin
            settle(); chk("no_preempt", 32'(o_gnt), 32'h1); tick();
        end
        bus.i_xfer_done = 1'b1; settle(); tick();
        bus.i_xfer_done = 1'b0; settle(); tick();

        // Reset in the middle of a transfer drops everything at once.
        settle(); tick();
        i_rq_start = 2'b10; settle(); tick();
        i_rq_start = 2'b00; i_rq_addr_valid = 2'b11;
        #2 i_rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(o_gnt), 32'd0);
        chk("arst_outs", 32'({bus.o_addr_valid, bus.o_addr_bits, o_rq_addr_ready}), 32'd0);
        chk("arst_nack", 32'(o_nack_src), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0; model_reset();
        i_req = 2'b10;
        settle(); tick();
        settle(); chk("post_rst_gnt", 32'(o_gnt), 32'h2); tick();

        // Random traffic.
        for (int s = 0; s < 3000; s++) begin
            if ($urandom_range(0, 3) == 0) i_req = 2'($urandom);
            i_rq_start      = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            bus.i_xfer_done = ($urandom_range(0, 5) == 0);
            bus.i_nack      = ($urandom_range(0, 7) == 0);
            settle(); tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_arbiter.md
I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 SHALL have parameter DATA_DEPTH, default 8: width of every address, byte-count and data bus.
REQ-002 SHALL have parameter TIMEOUT, default 255: number of granted cycles allowed without a start before the grant is revoked.
REQ-003 SHALL have port i_clk, in, 1: clock; all state changes on the rising edge.
REQ-004 SHALL have port i_rst, in, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_req, in, 2: bit k set means requester k wants the I2C master.
REQ-006 SHALL have port o_gnt, out, 2: one-hot grant, or all-zero.
REQ-007 SHALL have port i_rq_start, in, 2: per-requester transaction start.
REQ-008 SHALL have ports i_rq_addr_bits, i_rq_nbytes_bits and i_rq_wdata_bits, in, 2*DATA_DEPTH each: requester k occupies slice [k*DATA_DEPTH +: DATA_DEPTH].
REQ-009 SHALL have ports i_rq_addr_valid, i_rq_nbytes_valid and i_rq_wdata_valid, in, 2 each: per-requester valids.
REQ-010 SHALL have ports o_rq_addr_ready, o_rq_nbytes_ready and o_rq_wdata_ready, out, 2 each: per-requester readys.
REQ-011 SHALL have port o_rq_rdata_bits, out, DATA_DEPTH: read data broadcast to both requesters.
REQ-012 SHALL have ports o_rq_rdata_valid, out, 2, and i_rq_rdata_ready, in, 2: per-requester read handshake.
REQ-013 SHALL have master-side outputs o_start, o_addr_bits/o_addr_valid, o_nbytes_bits/o_nbytes_valid, o_data_write_bits/o_data_write_valid and o_data_read_ready.
REQ-014 SHALL have master-side inputs i_addr_ready, i_nbytes_ready, i_data_write_ready, i_data_read_bits/i_data_read_valid, i_xfer_done (1-cycle pulse at stop) and i_nack (1-cycle pulse).
REQ-015 SHALL have port o_timeout, out, 1: 1-cycle pulse when a grant is revoked by timeout.
REQ-016 SHALL have port o_nack_src, out, 2: one-hot requester that received the last NACK; holds until the next NACK.

Function
REQ-017 SHALL implement states IDLE, GRANT, BUSY and GAP.
REQ-018 In IDLE with any i_req bit set, the FSM SHALL go to GRANT next cycle; o_gnt is asserted from that cycle.
REQ-019 Arbitration SHALL be round-robin: when both request, grant the requester not served last; after reset, requester 0 has priority.
REQ-020 In GRANT, i_rq_start of the granted requester SHALL go to BUSY; the winner's i_req dropping SHALL go to GAP.
REQ-021 In GRANT, a timeout counter SHALL reach TIMEOUT-1 without a start, then pulse o_timeout and go to GAP.
REQ-022 In BUSY, i_xfer_done SHALL go to GAP; i_req is ignored until then, so a transaction is never preempted.
REQ-023 GAP SHALL last exactly 1 cycle with o_gnt=0, then go to IDLE; it updates the last-served pointer.
REQ-024 In GRANT/BUSY, master outputs SHALL combinationally equal the granted requester's inputs; o_start = granted i_rq_start.
REQ-025 In IDLE/GAP, all master outputs SHALL be 0.
REQ-026 Master readys SHALL route only to the granted requester; the ungranted requester's readys and read valid SHALL be 0.
REQ-027 o_rq_rdata_bits SHALL be i_data_read_bits unconditionally; o_data_read_ready = granted i_rq_rdata_ready.
REQ-028 i_nack in BUSY SHALL load o_nack_src with o_gnt; a NACK outside BUSY SHALL be ignored.
REQ-029 When i_xfer_done and i_nack occur in the same cycle, both SHALL take effect.
REQ-030 i_rq_start from the ungranted requester SHALL be dropped, never queued.
REQ-031 The timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits and SHALL clear on entering GRANT.

Reset
REQ-032 i_rst SHALL force IDLE, o_gnt=0, pointer=requester 1 (so requester 0 wins first), counter=0, o_nack_src=0 and o_timeout=0, with all master outputs 0.
REQ-033 Reset mid-BUSY SHALL drop the grant immediately, with no stop generated by this block.

Structure
REQ-034 The shared package SHALL hold the state encoding (IDLE=0, GRANT=1, BUSY=2, GAP=3), the requester count of 2, and the default TIMEOUT.
REQ-035 There SHALL be one sub-module, rr_pick2: a 2-input round-robin picker (req, last-served -> one-hot).

Verification
REQ-036 Reset, then i_req=2'b11 -> o_gnt=2'b01 on cycle 2; after start+done+GAP, o_gnt=2'b10.
REQ-037 Req0 granted, i_rq_start[0]=1 with addr 8'h4E -> o_start=1, o_addr_bits=8'h4E, o_rq_addr_ready[1]=0 while i_addr_ready=1.
REQ-038 Req1 granted and no start for 255 cycles -> o_timeout pulses on cycle 255 of GRANT, then o_gnt=0 for one cycle.
REQ-039 i_nack with i_xfer_done in the same cycle while req1 is BUSY -> o_nack_src=2'b10, state GAP.
REQ-040 i_rst asserted mid-BUSY -> all outputs 0 asynchronously; after release, i_req=2'b10 -> o_gnt=2'b10.
REQ-041 In BUSY, drop i_req[0] and raise i_req[1] -> o_gnt stays 2'b01 until i_xfer_done.
